defec_descr_crc: RTL and testbench
==================================

DEFEC_DESCR_CRC -- requirements
Module: defec_descr_crc

Interface
REQ-001 Parameter pDATA_BYTES, 238, payload bytes per frame (CRC excluded).
REQ-002 Parameter pCRC_W, 16, CRC field width in bits.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 isop  input  1  first bit of frame; qualified by ival.
REQ-006 ival  input  1  idat valid; no backpressure exists.
REQ-007 idat  input  1  hard-decision bit from decoder 4x1 P2S, frame order.
REQ-008 osop  output  1  with first payload byte.
REQ-009 oval  output  1  odat valid.
REQ-010 odat  output  8  descrambled payload byte, first received bit in odat[7].
REQ-011 oeop  output  1  with byte pDATA_BYTES.
REQ-012 ocrc_val  output  1  single-cycle frame-result strobe.
REQ-013 ocrc_ok  output  1  CRC pass; valid only while ocrc_val is high.
REQ-014 ofrm_cnt  output  16  frames completed, wraps.
REQ-015 oerr_cnt  output  16  failed or aborted frames, saturates at 16'hFFFF.

Function
REQ-016 Frame SHALL be pDATA_BYTES*8 payload bits followed by pCRC_W CRC bits: 1920 bits at defaults.
REQ-017 FSM SHALL use states IDLE, DATA, CRC, REPORT.
- IDLE->DATA on isop&ival.
- DATA->CRC after bit 1904.
- CRC->REPORT after bit 1920.
- REPORT->IDLE unconditionally after one cycle.
REQ-018 CRC SHALL be CRC-16-CCITT, poly 0x1021, init 0xFFFF, MSB-first, no final XOR, computed over the received (scrambled) payload bits.
REQ-019 Frame SHALL pass when the register after the payload bits equals the 16 received CRC bits, compared MSB-first.
REQ-020 Descrambler SHALL be additive, 1+x^14+x^15, seed 15'h4A80, reloaded on every isop, stepping once per payload ival; CRC bits SHALL NOT advance it.
REQ-021 Byte output SHALL occur one cycle after the ival of its 8th bit; osop on byte 1, oeop on byte 238.
REQ-022 ocrc_val SHALL assert one cycle after the ival of the last CRC bit; counters SHALL update in the same cycle.
REQ-023 isop&ival in DATA or CRC SHALL abort the frame: ocrc_val=1 with ocrc_ok=0 next cycle, oerr_cnt+1, no oeop, and the same bit starts a new frame.
REQ-024 isop in REPORT SHALL be accepted as the start of the next frame, with no bit lost.
REQ-025 ival without isop in IDLE SHALL be discarded.
REQ-026 Gaps in ival of any length SHALL be tolerated; state holds.

Reset
REQ-027 On rst low, all outputs SHALL be 0, the FSM SHALL be IDLE, and the CRC, descrambler and bit/byte counters SHALL be cleared.
REQ-028 Reset mid-frame SHALL discard the partial frame with no ocrc_val and no counter change.

Configuration
REQ-029 With DEFEC_CRC_CHECK_EN defined, REQ-018/019 apply.
REQ-030 Without DEFEC_CRC_CHECK_EN:
- CRC bits are stripped unchecked.
- ocrc_ok=1 on every complete frame.
- oerr_cnt counts aborts only.
- CRC logic is absent.

Structure
REQ-031 Package defec_pkg SHALL hold the FSM state enum, CRC poly/init, scrambler poly/seed and the frame-length localparams shared with the encoder side.
REQ-032 Descrambler SHALL be sub-module descrambler (isop/ival/idat in, odat out, zero latency).

Verification
REQ-033 238 bytes 0x00..0xED, encoder-scrambled with valid CRC, ival=1 continuous -> bytes match, osop/oeop correct, ocrc_ok=1, ofrm_cnt=1.
REQ-034 Same frame with payload bit 100 flipped -> ocrc_ok=0, oerr_cnt=1, byte 13 differs in exactly one bit.
REQ-035 Frame with ival random 50% -> output identical to REQ-033.
REQ-036 isop at bit 500 -> abort strobe with ocrc_ok=0, then a clean frame passes; oerr_cnt=1, ofrm_cnt=1.
REQ-037 Back-to-back frames, second isop in REPORT cycle, and rst pulse at bit 1000 -> no lost bits, and no strobe after reset.
REQ-038 Build without DEFEC_CRC_CHECK_EN with corrupted CRC -> ocrc_ok=1, oerr_cnt=0.

Source files
------------

// File: rtl/defec_pkg.sv
// Constants and types shared by the DEFEC encoder and decoder paths.
// Frame geometry, CRC-16-CCITT parameters, descrambler polynomial and seed, and the FSM state enum.
package defec_pkg;
  typedef enum logic [1:0] {IDLE, DATA, CRC, REPORT} state_t;

  localparam int DATA_BYTES = 238;
  localparam int CRC_W      = 16;
  localparam int DATA_BITS  = DATA_BYTES * 8;
  localparam int FRAME_BITS = DATA_BITS + CRC_W;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // 1+x^14+x^15: the two oldest stages (bits 1 and 0) feed back into bit 14
  localparam logic [14:0] SCR_TAPS = 15'h0003;
  localparam logic [14:0] SCR_SEED = 15'h4A80;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic [15:0] nxt;
    nxt = {crc[14:0], 1'b0};
    if (crc[15] ^ din) nxt = nxt ^ CRC_POLY;
    return nxt;
  endfunction
endpackage

// File: rtl/descrambler.sv
// Additive PRBS descrambler with zero latency; the seed is reloaded on the bit that carries isop.
module descrambler
  import defec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic isop,
  input  logic ival,
  input  logic idat,
  output logic odat
);
  logic [14:0] lfsr;
  logic [14:0] cur;
  logic        key;

  assign cur  = isop ? SCR_SEED : lfsr;
  assign key  = ^(cur & SCR_TAPS);
  assign odat = idat ^ key;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= '0;
    end else if (ival) begin
      lfsr <= {key, cur[14:1]};
    end
  end
endmodule

// File: rtl/defec_descr_crc.sv
// Frame descrambler, byte packer and CRC checker behind the decoder's serial output.
// Define DEFEC_CRC_CHECK_EN to check the CRC field; otherwise it is stripped unchecked.
module defec_descr_crc
  import defec_pkg::*;
#(
  parameter int pDATA_BYTES = DATA_BYTES,
  parameter int pCRC_W      = CRC_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        isop,
  input  logic        ival,
  input  logic        idat,
  output logic        osop,
  output logic        oval,
  output logic [7:0]  odat,
  output logic        oeop,
  output logic        ocrc_val,
  output logic        ocrc_ok,
  output logic [15:0] ofrm_cnt,
  output logic [15:0] oerr_cnt
);
  localparam int PAY_BITS = pDATA_BYTES * 8;
  localparam int TOT_BITS = PAY_BITS + pCRC_W;
  localparam int CNT_W    = $clog2(TOT_BITS + 1);

  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAY_BITS - 1);
  localparam logic [CNT_W-1:0] TOT_LAST  = CNT_W'(TOT_BITS - 1);
  localparam logic [CNT_W-4:0] LAST_BYTE = (CNT_W-3)'(pDATA_BYTES - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_idx;
  logic [6:0]       byte_sr;
  logic             start;
  logic             abort;
  logic             pay_bit;
  logic             crc_bit;
  logic             descr_bit;
  logic             crc_pass;

  // A qualified isop always opens a frame, even mid-frame or in the REPORT cycle
  assign start   = ival & isop;
  assign abort   = start & ((state == DATA) | (state == CRC));
  assign bit_idx = start ? '0 : bit_cnt;
  assign pay_bit = ival & (start | (state == DATA));
  assign crc_bit = ival & ~isop & (state == CRC);

  descrambler u_descr (
    .clk  (clk),
    .rst  (rst),
    .isop (isop),
    .ival (pay_bit),
    .idat (idat),
    .odat (descr_bit)
  );

`ifdef DEFEC_CRC_CHECK_EN
  logic [15:0]       crc;
  logic [15:0]       crc_base;
  logic [pCRC_W-1:0] rx_crc;

  assign crc_base = start ? CRC_INIT : crc;
  assign crc_pass = (crc == {rx_crc[pCRC_W-2:0], idat});

  // CRC runs over the scrambled line bits; the received field is collected MSB-first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc    <= '0;
      rx_crc <= '0;
    end else begin
      if (pay_bit) crc <= crc16_step(crc_base, idat);
      if (crc_bit) rx_crc <= {rx_crc[pCRC_W-2:0], idat};
    end
  end
`else
  assign crc_pass = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      byte_sr  <= '0;
      osop     <= 1'b0;
      oval     <= 1'b0;
      odat     <= '0;
      oeop     <= 1'b0;
      ocrc_val <= 1'b0;
      ocrc_ok  <= 1'b0;
      ofrm_cnt <= '0;
      oerr_cnt <= '0;
    end else begin
      oval     <= 1'b0;
      osop     <= 1'b0;
      oeop     <= 1'b0;
      ocrc_val <= 1'b0;
      ocrc_ok  <= 1'b0;

      if (abort) begin
        ocrc_val <= 1'b1;
        if (oerr_cnt != 16'hFFFF) oerr_cnt <= oerr_cnt + 16'd1;
      end

      if (pay_bit) begin
        byte_sr <= {byte_sr[5:0], descr_bit};
        bit_cnt <= bit_idx + 1'b1;
        if (bit_idx[2:0] == 3'd7) begin
          oval <= 1'b1;
          odat <= {byte_sr, descr_bit};
          osop <= (bit_idx[CNT_W-1:3] == '0);
          oeop <= (bit_idx[CNT_W-1:3] == LAST_BYTE);
        end
        state <= (bit_idx == PAY_LAST) ? CRC : DATA;
      end else if (crc_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == TOT_LAST) begin
          state    <= REPORT;
          ocrc_val <= 1'b1;
          ocrc_ok  <= crc_pass;
          ofrm_cnt <= ofrm_cnt + 16'd1;
          if (!crc_pass && oerr_cnt != 16'hFFFF) oerr_cnt <= oerr_cnt + 16'd1;
        end
      end else if (state == REPORT) begin
        state   <= IDLE;
        bit_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_defec_descr_crc.sv
// Self-checking bench for defec_descr_crc: frame-level reference model plus directed and random frames.
// Expectations follow DEFEC_CRC_CHECK_EN the same way the design build does.
module tb_defec_descr_crc;
  localparam int DBYTES = 238;
  localparam int DBITS  = DBYTES * 8;
  localparam int FBITS  = DBITS + 16;

`ifdef DEFEC_CRC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic        oval;
    logic        osop;
    logic        oeop;
    logic [7:0]  odat;
    logic        cval;
    logic        cok;
    logic [15:0] frm;
    logic [15:0] err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        isop = 1'b0;
  logic        ival = 1'b0;
  logic        idat = 1'b0;
  logic        osop, oval, oeop, ocrc_val, ocrc_ok;
  logic [7:0]  odat;
  logic [15:0] ofrm_cnt, oerr_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  bit         ks[DBITS];
  logic [7:0] pay[DBYTES];
  bit         tx[$];
  exp_t       expq[$];
  logic [7:0] cap[$];
  logic       cap_ok[$];

  bit m_in = 1'b0;
  bit m_bits[$];
  int m_frm = 0;
  int m_err = 0;

  defec_descr_crc #(.pDATA_BYTES(DBYTES), .pCRC_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .isop     (isop),
    .ival     (ival),
    .idat     (idat),
    .osop     (osop),
    .oval     (oval),
    .odat     (odat),
    .oeop     (oeop),
    .ocrc_val (ocrc_val),
    .ocrc_ok  (ocrc_ok),
    .ofrm_cnt (ofrm_cnt),
    .oerr_cnt (oerr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
  endtask

  function automatic logic [15:0] crc_bits(input bit q[$], input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      if (c[15] ^ q[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Keystream as a bit sequence: b[m] = b[m-15] ^ b[m-14], first key bit is b[15]
  task automatic make_keystream();
    bit b[DBITS + 15];
    logic [14:0] seed = 15'h4A80;
    for (int j = 0; j < 15; j++) b[j] = seed[j];
    for (int m = 15; m < DBITS + 15; m++) b[m] = b[m-15] ^ b[m-14];
    for (int n = 0; n < DBITS; n++) ks[n] = b[n+15];
  endtask

  function automatic logic [7:0] ks_byte(input int k);
    logic [7:0] v = '0;
    for (int j = 0; j < 8; j++) v[7-j] = ks[k*8+j];
    return v;
  endfunction

  task automatic build_frame();
    logic [15:0] c;
    tx.delete();
    for (int i = 0; i < DBITS; i++) tx.push_back(pay[i/8][7 - i%8] ^ ks[i]);
    c = crc_bits(tx, DBITS);
    for (int k = 15; k >= 0; k--) tx.push_back(c[k]);
  endtask

  task automatic model_step(input logic sop, input logic val, input logic dat, output exp_t e);
    int n;
    logic [15:0] rx;
    bit ok;
    e = '0;
    if (val && sop) begin
      if (m_in) begin
        e.cval = 1'b1;
        e.cok  = 1'b0;
        if (m_err < 65535) m_err++;
      end
      m_bits.delete();
      m_in = 1'b1;
    end
    if (val && m_in) begin
      m_bits.push_back(dat);
      n = m_bits.size();
      if (n <= DBITS && n % 8 == 0) begin
        e.oval = 1'b1;
        e.osop = (n == 8);
        e.oeop = (n == DBITS);
        for (int j = 0; j < 8; j++) e.odat[7-j] = m_bits[n-8+j] ^ ks[n-8+j];
      end
      if (n == FBITS) begin
        for (int k = 0; k < 16; k++) rx[15-k] = m_bits[DBITS+k];
        ok = CHK ? (crc_bits(m_bits, DBITS) == rx) : 1'b1;
        e.cval = 1'b1;
        e.cok  = ok;
        m_frm++;
        if (!ok && m_err < 65535) m_err++;
        m_in = 1'b0;
      end
    end
    e.frm = 16'(m_frm);
    e.err = 16'(m_err);
  endtask

  task automatic drive_cycle(input logic sop, input logic val, input logic dat);
    exp_t e;
    @(negedge clk);
    isop = sop;
    ival = val;
    idat = dat;
    model_step(sop, val, dat, e);
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; isop = 1'b0; ival = 1'b0; idat = 1'b0;
    m_in = 1'b0; m_bits.delete(); m_frm = 0; m_err = 0;
    expq.push_back('0);
    @(negedge clk);
    expq.push_back('0);
    @(negedge clk);
    rst = 1'b1;
    expq.push_back('0);
    cap.delete();
    cap_ok.delete();
  endtask

  task automatic apply_stimulus(input int nbits, input int gap_pct);
    for (int i = 0; i < nbits; i++) begin
      while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct)
        drive_cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      drive_cycle(i == 0, 1'b1, tx[i]);
    end
  endtask

  task automatic check_output(input exp_t e);
    exp_t a;
    a.oval = oval; a.osop = osop; a.oeop = oeop; a.odat = odat;
    a.cval = ocrc_val; a.cok = ocrc_ok; a.frm = ofrm_cnt; a.err = oerr_cnt;
    if (!e.oval) begin a.odat = '0; e.odat = '0; end
    if (!e.cval) begin a.cok = 1'b0; e.cok = 1'b0; end
    n_checks++;
    if (a === e) n_pass++;
    else $display("[TB] FAIL cycle_outputs @%0t: got val=%b sop=%b eop=%b dat=%h crcv=%b ok=%b frm=%0d err=%0d, want val=%b sop=%b eop=%b dat=%h crcv=%b ok=%b frm=%0d err=%0d",
                  $time, a.oval, a.osop, a.oeop, a.odat, a.cval, a.cok, a.frm, a.err,
                  e.oval, e.osop, e.oeop, e.odat, e.cval, e.cok, e.frm, e.err);
  endtask

  // One compare process: each negedge expectation is checked just after the following posedge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check_output(e);
      end
      if (oval === 1'b1) cap.push_back(odat);
      if (ocrc_val === 1'b1) cap_ok.push_back(ocrc_ok);
    end
  end

  function automatic int byte_errs(input int base);
    int n = 0;
    for (int i = 0; i < DBYTES; i++)
      if (cap.size() <= base + i || cap[base+i] !== 8'(i)) n++;
    return n;
  endfunction

  function automatic logic ok_at(input int k);
    return (cap_ok.size() > k) ? cap_ok[k] : 1'bx;
  endfunction

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit s[$];
    string str = "123456789";
    logic [7:0] ch;

    make_keystream();
    check("pin_prbs_byte0", 64'(ks_byte(0)), 64'h03);
    check("pin_prbs_byte1", 64'(ks_byte(1)), 64'hF6);
    for (int i = 0; i < str.len(); i++) begin
      ch = str[i];
      for (int k = 7; k >= 0; k--) s.push_back(ch[k]);
    end
    check("pin_crc_check_string", 64'(crc_bits(s, s.size())), 64'h29B1);

    do_reset();
    check("reset_state", 64'({osop, oval, oeop, ocrc_val, ocrc_ok, odat, ofrm_cnt, oerr_cnt}), 64'h0);

    // Reference frame, continuous ival
    for (int i = 0; i < DBYTES; i++) pay[i] = 8'(i);
    build_frame();
    apply_stimulus(FBITS, 0);
    idle(3);
    check("ref_byte_count", 64'(cap.size()), 64'd238);
    check("ref_bytes", 64'(byte_errs(0)), 64'd0);
    check("ref_crc_ok", 64'(ok_at(0)), 64'd1);
    check("ref_frm_cnt", 64'(ofrm_cnt), 64'd1);
    check("ref_err_cnt", 64'(oerr_cnt), 64'd0);

    // Payload bit 100 flipped
    do_reset();
    build_frame();
    tx[100] = ~tx[100];
    apply_stimulus(FBITS, 0);
    idle(3);
    check("flip_crc_ok", 64'(ok_at(0)), 64'(!CHK));
    check("flip_err_cnt", 64'(oerr_cnt), 64'(CHK));
    check("flip_byte13_onebit", 64'((cap.size() > 12) ? $countones(cap[12] ^ 8'h0C) : 0), 64'd1);

    // 50% ival gaps
    do_reset();
    build_frame();
    apply_stimulus(FBITS, 50);
    idle(3);
    check("gap_bytes", 64'(byte_errs(0)), 64'd0);
    check("gap_crc_ok", 64'(ok_at(0)), 64'd1);

    // Abort at bit 500, then a clean frame
    do_reset();
    apply_stimulus(500, 0);
    apply_stimulus(FBITS, 0);
    idle(3);
    check("abort_strobes", 64'(cap_ok.size()), 64'd2);
    check("abort_first_ok", 64'(ok_at(0)), 64'd0);
    check("abort_second_ok", 64'(ok_at(1)), 64'd1);
    check("abort_frm_cnt", 64'(ofrm_cnt), 64'd1);
    check("abort_err_cnt", 64'(oerr_cnt), 64'd1);

    // Back-to-back frames (second isop in REPORT), then reset mid-frame
    do_reset();
    apply_stimulus(FBITS, 0);
    apply_stimulus(FBITS, 0);
    idle(2);
    check("b2b_second_bytes", 64'(byte_errs(238)), 64'd0);
    check("b2b_frm_cnt", 64'(ofrm_cnt), 64'd2);
    apply_stimulus(1000, 0);
    do_reset();
    idle(4);
    check("post_reset_no_strobe", 64'(cap_ok.size()), 64'd0);
    apply_stimulus(FBITS, 0);
    idle(3);
    check("post_reset_frm_cnt", 64'(ofrm_cnt), 64'd1);

    // Corrupted CRC field
    do_reset();
    build_frame();
    tx[FBITS-1] = ~tx[FBITS-1];
    apply_stimulus(FBITS, 0);
    idle(3);
    check("badcrc_ok", 64'(ok_at(0)), 64'(!CHK));
    check("badcrc_err_cnt", 64'(oerr_cnt), 64'(CHK));

    // Random payloads, gaps, stray ival, aborts and corruption
    do_reset();
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < DBYTES; i++) pay[i] = 8'($urandom_range(0, 255));
      build_frame();
      if ($urandom_range(0, 2) == 0) tx[$urandom_range(0, FBITS-1)] ^= 1'b1;
      for (int k = 0; k < int'($urandom_range(0, 5)); k++) drive_cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) apply_stimulus(int'($urandom_range(1, FBITS-1)), 0);
      apply_stimulus(FBITS, int'($urandom_range(0, 60)));
    end
    idle(4);

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
